fetch_sequencer: RTL and testbench

//   Front-end controller of the pipelined RISC core. Owns the PC and the IF/ID register.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_perf_counter.sv | 22 ++
 rtl/fetch_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front-end.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    IMM   = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  localparam logic [15:0] NOP_INSTR   = 16'h0000;
  localparam logic [4:0]  HLT_OP_DEF  = 5'b00001;
  localparam int          IMM_BIT_DEF = 2;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating 16-bit event counter; holds at all-ones, cleared only by reset.
module fetch_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;

  // count events, stop at the top value instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 16'h0000;
    end else if (inc_i && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'h0001;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch front-end: PC, IF/ID register and one/two-word instruction sequencing.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined;
// otherwise bubble_cnt and stall_cnt are constant zero.
//
// state | meaning
// FETCH | fetching a new instruction word at pc
// IMM   | first word of a two-word instruction held; fetching its immediate
// HALT  | HLT issued; pc frozen, IF/ID drives NOP until a jump or reset
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int             AW       = 16,
  parameter int             IW       = 16,
  parameter logic [AW-1:0]  RESET_PC = '0,
  parameter int             IMM_BIT  = IMM_BIT_DEF,
  parameter logic [4:0]     HLT_OP   = HLT_OP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr_in,
  output logic [AW-1:0] pc,
  input  logic          stall,
  input  logic          jump_taken,
  input  logic [AW-1:0] jump_target,
  output logic [IW-1:0] ifid_instr,
  output logic [IW-1:0] ifid_imm,
  output logic          ifid_valid,
  output logic          ifid_bubble,
  output logic          halted,
  output logic [15:0]   bubble_cnt,
  output logic [15:0]   stall_cnt
);

  localparam logic [IW-1:0] NOP = IW'(NOP_INSTR);

  fetch_state_e  state_q,   state_d;
  logic [AW-1:0] pc_q,      pc_d;
  logic [IW-1:0] instr_q,   instr_d;
  logic [IW-1:0] imm_q,     imm_d;
  logic          valid_q,   valid_d;
  logic          bubble_q,  bubble_d;
  logic [IW-1:0] pending_q, pending_d;

  logic word_has_imm;
  logic word_is_hlt;

  assign word_has_imm = instr_in[IMM_BIT];
  assign word_is_hlt  = (instr_in[IW-1:IW-5] == HLT_OP);

  // state, pc, pending word and IF/ID register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      imm_q     <= '0;
      valid_q   <= 1'b0;
      bubble_q  <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      valid_q   <= valid_d;
      bubble_q  <= bubble_d;
      pending_q <= pending_d;
    end
  end

  // next state: jump beats stall beats normal sequencing; stall holds everything
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    valid_d   = valid_q;
    bubble_d  = bubble_q;
    pending_d = pending_q;

    if (jump_taken) begin
      state_d   = FETCH;
      pc_d      = jump_target;
      instr_d   = NOP;
      imm_d     = '0;
      valid_d   = 1'b0;
      bubble_d  = 1'b0;
      pending_d = '0;
    end else if (!stall) begin
      case (state_q)
        FETCH: begin
          pc_d = pc_q + AW'(1);
          if (word_has_imm) begin
            pending_d = instr_in;
            instr_d   = NOP;
            imm_d     = '0;
            valid_d   = 1'b0;
            bubble_d  = 1'b1;
            state_d   = IMM;
          end else begin
            instr_d  = instr_in;
            imm_d    = '0;
            valid_d  = 1'b1;
            bubble_d = 1'b0;
            if (word_is_hlt) state_d = HALT;
          end
        end
        IMM: begin
          pc_d     = pc_q + AW'(1);
          instr_d  = pending_q;
          imm_d    = instr_in;
          valid_d  = 1'b1;
          bubble_d = 1'b0;
          state_d  = FETCH;
        end
        HALT: begin
          instr_d  = NOP;
          imm_d    = '0;
          valid_d  = 1'b0;
          bubble_d = 1'b0;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign ifid_instr  = instr_q;
  assign ifid_imm    = imm_q;
  assign ifid_valid  = valid_q;
  assign ifid_bubble = bubble_q;
  assign halted      = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
  logic bubble_inc;
  logic stall_inc;

  assign bubble_inc = !jump_taken && !stall && (state_q == FETCH) && word_has_imm;
  assign stall_inc  = stall && !jump_taken;

  fetch_perf_counter u_bubble_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (bubble_inc),
    .count_o (bubble_cnt)
  );

  fetch_perf_counter u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stall_inc),
    .count_o (stall_cnt)
  );
`else
  assign bubble_cnt = 16'h0000;
  assign stall_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_in;
  logic [15:0] pc;
  logic        stall;
  logic        jump_taken;
  logic [15:0] jump_target;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_imm;
  logic        ifid_valid;
  logic        ifid_bubble;
  logic        halted;
  logic [15:0] bubble_cnt;
  logic [15:0] stall_cnt;

  logic [15:0] mem [0:65535];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign instr_in = mem[pc];

  fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instr_in),
    .pc          (pc),
    .stall       (stall),
    .jump_taken  (jump_taken),
    .jump_target (jump_target),
    .ifid_instr  (ifid_instr),
    .ifid_imm    (ifid_imm),
    .ifid_valid  (ifid_valid),
    .ifid_bubble (ifid_bubble),
    .halted      (halted),
    .bubble_cnt  (bubble_cnt),
    .stall_cnt   (stall_cnt)
  );

  // behavioural model: what decode should see, derived from the fetch rules
  logic [15:0] m_pc, m_instr, m_imm, m_held;
  logic        m_valid, m_bub, m_halt, m_wait;
  int          m_bcnt, m_scnt;

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_imm = 16'h0000; m_held = 16'h0000;
    m_valid = 1'b0; m_bub = 1'b0; m_halt = 1'b0; m_wait = 1'b0;
    m_bcnt = 0; m_scnt = 0;
  endtask

  task automatic model_edge(input logic s, input logic j, input logic [15:0] t);
    logic [15:0] w;
    w = mem[m_pc];
    if (j) begin
      m_pc = t; m_instr = 16'h0000; m_imm = 16'h0000;
      m_valid = 1'b0; m_bub = 1'b0; m_wait = 1'b0; m_halt = 1'b0;
    end else if (s) begin
      if (m_scnt < 65535) m_scnt++;
    end else if (m_halt) begin
      m_instr = 16'h0000; m_imm = 16'h0000; m_valid = 1'b0; m_bub = 1'b0;
    end else if (m_wait) begin
      m_instr = m_held; m_imm = w; m_valid = 1'b1; m_bub = 1'b0;
      m_wait = 1'b0; m_pc = m_pc + 16'd1;
    end else if (w[2]) begin
      m_held = w; m_instr = 16'h0000; m_imm = 16'h0000; m_valid = 1'b0; m_bub = 1'b1;
      m_wait = 1'b1; m_pc = m_pc + 16'd1;
      if (m_bcnt < 65535) m_bcnt++;
    end else begin
      m_instr = w; m_imm = 16'h0000; m_valid = 1'b1; m_bub = 1'b0;
      if (w[15:11] == 5'b00001) m_halt = 1'b1;
      m_pc = m_pc + 16'd1;
    end
  endtask

  function automatic logic [15:0] exp_bcnt();
`ifdef FETCH_PERF_CNT_EN
    return 16'(m_bcnt);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [15:0] exp_scnt();
`ifdef FETCH_PERF_CNT_EN
    return 16'(m_scnt);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},     32'(pc),          32'(m_pc));
    chk({tag, ".instr"},  32'(ifid_instr),  32'(m_instr));
    chk({tag, ".imm"},    32'(ifid_imm),    32'(m_imm));
    chk({tag, ".valid"},  32'(ifid_valid),  32'(m_valid));
    chk({tag, ".bubble"}, 32'(ifid_bubble), 32'(m_bub));
    chk({tag, ".halted"}, 32'(halted),      32'(m_halt));
    chk({tag, ".bcnt"},   32'(bubble_cnt),  32'(exp_bcnt()));
    chk({tag, ".scnt"},   32'(stall_cnt),   32'(exp_scnt()));
  endtask

  task automatic step(input logic s, input logic j, input logic [15:0] t);
    stall = s; jump_taken = j; jump_target = t;
    model_edge(s, j, t);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        s;
    logic        j;
    logic [15:0] t;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic [15:0] e_imm;
    logic        e_valid;
    logic        e_bub;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic j, input logic [15:0] t,
                     input logic [15:0] p, input logic [15:0] i, input logic [15:0] im,
                     input logic v, input logic b, input logic h);
    vec_t x;
    x.s = s; x.j = j; x.t = t; x.e_pc = p; x.e_instr = i; x.e_imm = im;
    x.e_valid = v; x.e_bub = b; x.e_halt = h;
    vecs.push_back(x);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    mem[0] = 16'h1230; mem[1] = 16'h2004; mem[2] = 16'hBEEF;
    mem[3] = 16'h3004; mem[4] = 16'hCAFE; mem[5] = 16'h0800;
    mem[6] = 16'h1111; mem[16'h0040] = 16'h4321; mem[16'hFFFF] = 16'h5004;

    rst = 1'b1; stall = 1'b0; jump_taken = 1'b0; jump_target = 16'h0000;
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    //   s  j  target    pc       instr    imm      v  b  h
    add(0, 0, 16'h0000, 16'h0001, 16'h1230, 16'h0000, 1, 0, 0);
    add(0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 0, 1, 0);
    add(0, 0, 16'h0000, 16'h0003, 16'h2004, 16'hBEEF, 1, 0, 0);
    add(0, 0, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 0, 1, 0);
    for (int k = 0; k < 3; k++)
      add(1, 0, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 0, 1, 0);
    add(0, 0, 16'h0000, 16'h0005, 16'h3004, 16'hCAFE, 1, 0, 0);
    add(0, 0, 16'h0000, 16'h0006, 16'h0800, 16'h0000, 1, 0, 1);
    for (int k = 0; k < 10; k++)
      add(0, 0, 16'h0000, 16'h0006, 16'h0000, 16'h0000, 0, 0, 1);
    add(0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 16'h0000, 16'h0001, 16'h1230, 16'h0000, 1, 0, 0);
    add(0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 0, 1, 0);
    add(1, 1, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 16'h0000, 16'h0041, 16'h4321, 16'h0000, 1, 0, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].s, vecs[k].j, vecs[k].t);
      chk($sformatf("vec%0d.pc", k),     32'(pc),          32'(vecs[k].e_pc));
      chk($sformatf("vec%0d.instr", k),  32'(ifid_instr),  32'(vecs[k].e_instr));
      chk($sformatf("vec%0d.imm", k),    32'(ifid_imm),    32'(vecs[k].e_imm));
      chk($sformatf("vec%0d.valid", k),  32'(ifid_valid),  32'(vecs[k].e_valid));
      chk($sformatf("vec%0d.bubble", k), 32'(ifid_bubble), 32'(vecs[k].e_bub));
      chk($sformatf("vec%0d.halted", k), 32'(halted),      32'(vecs[k].e_halt));
      chk($sformatf("vec%0d.bcnt", k),   32'(bubble_cnt),  32'(exp_bcnt()));
      chk($sformatf("vec%0d.scnt", k),   32'(stall_cnt),   32'(exp_scnt()));
    end
`ifdef FETCH_PERF_CNT_EN
    chk("table.stall_total",  32'(stall_cnt),  32'd3);
    chk("table.bubble_total", 32'(bubble_cnt), 32'd3);
`endif

    // two-word instruction straddling the top of the address space
    step(0, 1, 16'hFFFF);
    check_all("wrap.jump");
    step(0, 0, 16'h0000);
    chk("wrap.bubble", 32'(ifid_bubble), 32'd1);
    chk("wrap.pc0",    32'(pc),          32'h0000);
    step(0, 0, 16'h0000);
    chk("wrap.instr",  32'(ifid_instr),  32'h5004);
    chk("wrap.imm",    32'(ifid_imm),    32'h1230);
    chk("wrap.pc1",    32'(pc),          32'h0001);
    check_all("wrap.done");

    // asynchronous reset while waiting for an immediate
    step(0, 1, 16'hFFFF);
    step(0, 0, 16'h0000);
    check_all("midimm.pre");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("midimm.rst");
    @(posedge clk); #1;
    rst = 1'b0;
    step(0, 0, 16'h0000);
    chk("midimm.after_instr", 32'(ifid_instr), 32'h1230);
    check_all("midimm.after");

    // randomized run against the model
    for (int a = 0; a < 65536; a++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 15) == 0) w[15:11] = 5'b00001;
      mem[a] = w;
    end
    for (int n = 0; n < 2000; n++) begin
      logic s, j;
      s = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 9) == 0);
      step(s, j, 16'($urandom));
      check_all($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
